// File: rtl/uart_fmt_pkg.sv
// Shared types and constants for the decimal ASCII result transmitter.
package uart_fmt_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StSend,
        StWaitHi,
        StWaitLo,
        StGap
    } tx_fmt_state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    localparam int unsigned MAX_CHARS = 8;

    function automatic logic [7:0] digit_char(input logic [3:0] nibble);
        return ASCII_ZERO + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/bin16_to_bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5-digit BCD, one bit per cycle.
// start_i loads the operand; done_o pulses once bcd_o holds the final digits.
module bin16_to_bcd_seq (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic        done_o,
    output logic [19:0] bcd_o
);
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d, bcd_adj;
    logic [35:0] shifted;
    logic [3:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic        done_q, done_d;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;

        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            bcd_d = shifted[35:16];
            bin_d = shifted[15:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/uart_result_ascii_tx.sv
// Formats a 16-bit result as decimal ASCII (MSD first, optional CR LF) and
// streams it to a byte UART. Define SIGNED_FMT_EN for two's-complement output.
module uart_result_ascii_tx
    import uart_fmt_pkg::*;
#(
    parameter int unsigned INTER_BYTE_DELAY = 1000,
    parameter int unsigned BUSY_ACK_TIMEOUT = 100,
    parameter int unsigned SEND_CRLF        = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        trigger,
    input  logic [15:0] resultado,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done
);
    localparam int unsigned CntMax = (INTER_BYTE_DELAY > BUSY_ACK_TIMEOUT) ?
                                     INTER_BYTE_DELAY : BUSY_ACK_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    tx_fmt_state_t   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0]      len_q, len_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [7:0]      chars_q [MAX_CHARS];
    logic [7:0]      chars_d [MAX_CHARS];
    logic [7:0]      list_build [MAX_CHARS];
    logic [3:0]      list_len;
    logic            conv_start, conv_done;
    logic [15:0]     conv_bin;
    logic [19:0]     bcd;
    logic            lead;

`ifdef SIGNED_FMT_EN
    logic neg_q, neg_d;
    assign conv_bin = resultado[15] ? (~resultado + 16'd1) : resultado;
`else
    assign conv_bin = resultado;
`endif

    bin16_to_bcd_seq u_bcd (
        .clk     (clk),
        .resetN  (resetN),
        .start_i (conv_start),
        .bin_i   (conv_bin),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    // Character list from the finished BCD; d0 is always emitted.
    always_comb begin
        for (int i = 0; i < int'(MAX_CHARS); i++) begin
            list_build[i] = 8'h00;
        end
        list_len = 4'd0;
        lead     = 1'b0;
`ifdef SIGNED_FMT_EN
        if (neg_q) begin
            list_build[0] = ASCII_MINUS;
            list_len      = 4'd1;
        end
`endif
        for (int i = 4; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0 || lead || i == 0) begin
                list_build[list_len[2:0]] = digit_char(bcd[4*i +: 4]);
                list_len = list_len + 4'd1;
                lead     = 1'b1;
            end
        end
        if (SEND_CRLF != 0) begin
            list_build[list_len[2:0]] = ASCII_CR;
            list_len = list_len + 4'd1;
            list_build[list_len[2:0]] = ASCII_LF;
            list_len = list_len + 4'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        len_d      = len_q;
        tx_data_d  = tx_data_q;
        chars_d    = chars_q;
        conv_start = 1'b0;
        tx_start   = 1'b0;
        done       = 1'b0;
        busy       = (state_q != StIdle);
`ifdef SIGNED_FMT_EN
        neg_d      = neg_q;
`endif
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    conv_start = 1'b1;
`ifdef SIGNED_FMT_EN
                    neg_d      = resultado[15];
`endif
                    state_d    = StConv;
                end
            end
            StConv: begin
                if (conv_done) begin
                    chars_d   = list_build;
                    len_d     = list_len;
                    idx_d     = 3'd0;
                    tx_data_d = list_build[0];
                    state_d   = StSend;
                end
            end
            StSend: begin
                tx_start = 1'b1;
                cnt_d    = '0;
                state_d  = StWaitHi;
            end
            StWaitHi: begin
                // No acknowledge within the timeout: treat the byte as sent.
                if (tx_busy) begin
                    state_d = StWaitLo;
                end else if (cnt_q == CntW'(BUSY_ACK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLo: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(INTER_BYTE_DELAY - 1)) begin
                    if ({1'b0, idx_q} == len_q - 4'd1) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = chars_q[idx_q + 3'd1];
                        state_d   = StSend;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            tx_data_q <= 8'h00;
            for (int i = 0; i < int'(MAX_CHARS); i++) begin
                chars_q[i] <= 8'h00;
            end
`ifdef SIGNED_FMT_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            tx_data_q <= tx_data_d;
            chars_q   <= chars_d;
`ifdef SIGNED_FMT_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_result_ascii_tx.sv
// Bench for uart_result_ascii_tx: event-timing reference model checked every
// cycle, plus literal frame contents and latencies for directed values.
module tb_uart_result_ascii_tx;

    localparam int unsigned IBD      = 20;
    localparam int unsigned TO       = 100;
    localparam int unsigned CRLF     = 1;
    localparam int          BUSY_LEN = 10;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] resultado = 16'h0000;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    uart_result_ascii_tx #(
        .INTER_BYTE_DELAY (IBD),
        .BUSY_ACK_TIMEOUT (TO),
        .SEND_CRLF        (CRLF)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .trigger   (trigger),
        .resultado (resultado),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit uart_en = 1'b1;

    logic [7:0] log_q[$];
    int         start_t[$];
    int         done_cnt = 0;
    int         trig_t = -1;

    // Reference model state
    bit         m_busy = 1'b0;
    logic [7:0] m_q[$];
    int         m_next = -1;
    bit         m_wait_hi = 1'b0;
    bit         m_wait_lo = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Decimal text of a value by plain arithmetic.
    task automatic model_push(input logic [15:0] v);
        int         m;
        bit         neg;
        logic [7:0] t[$];
        m   = int'(v);
        neg = 1'b0;
`ifdef SIGNED_FMT_EN
        if (v[15]) begin
            neg = 1'b1;
            m   = 65536 - int'(v);
        end
`endif
        do begin
            t.push_front(8'(48 + m % 10));
            m = m / 10;
        end while (m > 0);
        if (neg) t.push_front(8'h2D);
        foreach (t[k]) m_q.push_back(t[k]);
        if (CRLF != 0) begin
            m_q.push_back(8'h0D);
            m_q.push_back(8'h0A);
        end
    endtask

    // UART stand-in: tx_busy high for BUSY_LEN cycles starting the cycle after tx_start.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_en && tx_start) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (BUSY_LEN) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit es;
        bit ed;
        es = m_busy && (m_q.size() > 0) && (cyc == m_next);
        ed = m_busy && (m_q.size() == 0) && (m_next >= 0) && (cyc == m_next - 1);
        check("tx_start", 32'(tx_start), 32'(es));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(ed));
        if (tx_start) begin
            log_q.push_back(tx_data);
            start_t.push_back(cyc);
            if (es) check("tx_data", 32'(tx_data), 32'(m_q[0]));
        end
        if (done) done_cnt++;
        if (!resetN) begin
            m_busy = 1'b0;
            m_q.delete();
            m_next = -1;
            m_wait_hi = 1'b0;
            m_wait_lo = 1'b0;
        end else begin
            if (!m_busy && trigger) begin
                m_busy = 1'b1;
                model_push(resultado);
                m_next = cyc + 18;
                trig_t = cyc;
            end
            if (ed) begin
                m_busy = 1'b0;
                m_next = -1;
                m_wait_hi = 1'b0;
                m_wait_lo = 1'b0;
            end
            if (es) begin
                void'(m_q.pop_front());
                m_next = cyc + 1 + int'(TO) + int'(IBD);
                m_wait_hi = 1'b1;
                m_wait_lo = 1'b0;
            end else if (m_wait_hi && tx_busy) begin
                m_wait_hi = 1'b0;
                m_wait_lo = 1'b1;
                m_next = -1;
            end else if (m_wait_lo && !tx_busy) begin
                m_wait_lo = 1'b0;
                m_next = cyc + int'(IBD) + 1;
            end
        end
        cyc++;
    end

    task automatic pulse(input logic [15:0] v);
        @(posedge clk);
        #1;
        resultado = v;
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", 32'(done_cnt != d0), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_log(input string name, input int n, input logic [63:0] bytes);
        logic [7:0] got;
        check({name, "_len"}, 32'(log_q.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            got = (k < log_q.size()) ? log_q[k] : 8'hxx;
            check({name, "_byte"}, 32'(got), 32'(bytes[8*(n-1-k) +: 8]));
        end
    endtask

    task automatic run_frame(input logic [15:0] v, input string name, input int n,
                             input logic [63:0] bytes, input int budget);
        int d0;
        log_q.delete();
        start_t.delete();
        d0 = done_cnt;
        pulse(v);
        wait_done(d0, budget);
        check_log(name, n, bytes);
        check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_first_latency"}, 32'((start_t.size() > 0) ? start_t[0] - trig_t : -1),
              32'd18);
    endtask

    initial begin
        int d0;
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 resetN = 1'b1;

        run_frame(16'd1234, "f1234", 6, 64'h0000_3132_3334_0D0A, 600);
        run_frame(16'd0, "f0", 3, 64'h0000_0000_0030_0D0A, 600);
        run_frame(16'd65535, "f65535", 7, 64'h0036_3535_3335_0D0A, 600);

        // Second trigger while busy is dropped.
        log_q.delete();
        start_t.delete();
        d0 = done_cnt;
        pulse(16'd1234);
        repeat (4) @(posedge clk);
        pulse(16'd999);
        wait_done(d0, 600);
        repeat (60) @(negedge clk);
        check_log("ignored", 6, 64'h0000_3132_3334_0D0A);
        check("ignored_done_pulses", 32'(done_cnt - d0), 32'd1);

        // UART absent: every byte advances on the acknowledge timeout.
        uart_en = 1'b0;
        run_frame(16'd42, "tmo", 4, 64'h0000_0000_3432_0D0A, 4 * int'(1 + TO + IBD) + 60);
        check("tmo_period", 32'((start_t.size() > 1) ? start_t[1] - start_t[0] : -1),
              32'(1 + TO + IBD));
        uart_en = 1'b1;
        repeat (20) @(posedge clk);

        // Reset during the third byte aborts the frame.
        log_q.delete();
        start_t.delete();
        d0 = done_cnt;
        pulse(16'd1234);
        k = 0;
        while (log_q.size() < 3 && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_reached_byte3", 32'(log_q.size()), 32'd3);
        repeat (3) @(posedge clk);
        #1 resetN = 1'b0;
        @(posedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
        check("rst_mid_tx_start", 32'(tx_start), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (100) @(negedge clk);
        check("rst_mid_no_resume", 32'(log_q.size()), 32'd3);
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        run_frame(16'd7, "f7", 3, 64'h0000_0000_0037_0D0A, 600);

`ifdef SIGNED_FMT_EN
        run_frame(16'hFFFF, "neg1", 4, 64'h0000_0000_2D31_0D0A, 600);
        run_frame(16'h8000, "negmin", 8, 64'h2D33_3237_3638_0D0A, 600);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
